// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_ctrl
//  Description : Load/store unit controller. Accepts AGU ICB commands, checks
//                alignment, issues one memory access at a time, extracts and
//                extends sub-word load data and retires through the LSU
//                write-back port.
//  Revision    : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
   parameter int XLEN      = 32,
   parameter int ADDR_SIZE = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   // AGU command channel
   input  logic                 agu_icb_cmd_valid,
   output logic                 agu_icb_cmd_ready,
   input  logic [ADDR_SIZE-1:0] agu_icb_cmd_addr,
   input  logic                 agu_icb_cmd_read,
   input  logic [XLEN-1:0]      agu_icb_cmd_wdata,
   input  logic [XLEN/8-1:0]    agu_icb_cmd_wmask,
   input  logic [1:0]           agu_icb_cmd_size,
   input  logic                 agu_icb_cmd_usign,
   output logic [XLEN-1:0]      agu_icb_rsp_rdata,
   // write-back / retire
   output logic                 lsu_o_valid,
   input  logic                 lsu_o_ready,
   output logic [XLEN-1:0]      lsu_o_wbck_wdat,
   output logic                 lsu_o_cmt_ld,
   output logic                 lsu_o_cmt_st,
   output logic                 lsu_o_misalgn,
   // memory port
   output logic                 mem_req_valid,
   input  logic                 mem_req_ready,
   output logic [ADDR_SIZE-1:0] mem_req_addr,
   output logic                 mem_req_read,
   output logic [XLEN-1:0]      mem_req_wdata,
   output logic [XLEN/8-1:0]    mem_req_wmask,
   input  logic                 mem_rsp_valid,
   input  logic [XLEN-1:0]      mem_rsp_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_WBCK = 2'd3
   } state_t;

   state_t                 state;
   logic [ADDR_SIZE-1:0]   addr_q;
   logic                   read_q;
   logic [XLEN-1:0]        wdata_q;
   logic [XLEN/8-1:0]      wmask_q;
   logic [1:0]             size_q;
   logic                   usign_q;
   logic                   misalgn_q;
   logic [XLEN-1:0]        result_q;

   logic                   cmd_misalgn;
   logic [XLEN-1:0]        shifted;
   logic [XLEN-1:0]        load_ext;

   // Half needs addr[0]=0, word (and the unused size 3) needs addr[1:0]=0.
   assign cmd_misalgn = ((agu_icb_cmd_size == 2'd1) & agu_icb_cmd_addr[0])
                      | (agu_icb_cmd_size[1] & (agu_icb_cmd_addr[1:0] != 2'b00));

   // Byte-lane extraction of the response word followed by sign/zero extension.
   always_comb begin
      shifted = mem_rsp_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'd0:    load_ext = {{(XLEN-8){~usign_q & shifted[7]}}, shifted[7:0]};
         2'd1:    load_ext = {{(XLEN-16){~usign_q & shifted[15]}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   // Access sequencing FSM: latch command, request, wait for response, retire.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         addr_q    <= '0;
         read_q    <= 1'b0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         size_q    <= 2'd0;
         usign_q   <= 1'b0;
         misalgn_q <= 1'b0;
         result_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (agu_icb_cmd_valid) begin
                  addr_q    <= agu_icb_cmd_addr;
                  read_q    <= agu_icb_cmd_read;
                  wdata_q   <= agu_icb_cmd_wdata;
                  // Loads never write, so the mask is forced to zero for them.
                  wmask_q   <= agu_icb_cmd_read ? '0 : agu_icb_cmd_wmask;
                  size_q    <= agu_icb_cmd_size;
                  usign_q   <= agu_icb_cmd_usign;
                  misalgn_q <= cmd_misalgn;
                  state     <= cmd_misalgn ? S_WBCK : S_REQ;
               end
            end
            S_REQ: begin
               if (mem_req_ready) begin
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  // A store response is only an ack; the result is kept.
                  if (read_q) begin
                     result_q <= load_ext;
                  end
                  state <= S_WBCK;
               end
            end
            S_WBCK: begin
               if (lsu_o_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from state and latched fields only.
   assign agu_icb_cmd_ready = (state == S_IDLE);
   assign agu_icb_rsp_rdata = result_q;

   assign mem_req_valid = (state == S_REQ);
   assign mem_req_addr  = {addr_q[ADDR_SIZE-1:2], 2'b00};
   assign mem_req_read  = read_q;
   assign mem_req_wdata = wdata_q;
   assign mem_req_wmask = wmask_q;

   assign lsu_o_valid     = (state == S_WBCK);
   assign lsu_o_cmt_ld    = lsu_o_valid & read_q;
   assign lsu_o_cmt_st    = lsu_o_valid & ~read_q;
   assign lsu_o_misalgn   = lsu_o_valid & misalgn_q;
   assign lsu_o_wbck_wdat = (lsu_o_valid & read_q & ~misalgn_q) ? result_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsu_ctrl
//  Description : Self-checking bench for lsu_ctrl: directed vector table,
//                randomized accesses against a reference model, and a
//                reset-during-access sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

   localparam int XLEN      = 32;
   localparam int ADDR_SIZE = 32;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 agu_icb_cmd_valid;
   logic                 agu_icb_cmd_ready;
   logic [ADDR_SIZE-1:0] agu_icb_cmd_addr;
   logic                 agu_icb_cmd_read;
   logic [XLEN-1:0]      agu_icb_cmd_wdata;
   logic [XLEN/8-1:0]    agu_icb_cmd_wmask;
   logic [1:0]           agu_icb_cmd_size;
   logic                 agu_icb_cmd_usign;
   logic [XLEN-1:0]      agu_icb_rsp_rdata;
   logic                 lsu_o_valid;
   logic                 lsu_o_ready;
   logic [XLEN-1:0]      lsu_o_wbck_wdat;
   logic                 lsu_o_cmt_ld;
   logic                 lsu_o_cmt_st;
   logic                 lsu_o_misalgn;
   logic                 mem_req_valid;
   logic                 mem_req_ready;
   logic [ADDR_SIZE-1:0] mem_req_addr;
   logic                 mem_req_read;
   logic [XLEN-1:0]      mem_req_wdata;
   logic [XLEN/8-1:0]    mem_req_wmask;
   logic                 mem_rsp_valid;
   logic [XLEN-1:0]      mem_rsp_rdata;

   lsu_ctrl #(.XLEN(XLEN), .ADDR_SIZE(ADDR_SIZE)) dut (
      .clk               (clk),
      .rst               (rst),
      .agu_icb_cmd_valid (agu_icb_cmd_valid),
      .agu_icb_cmd_ready (agu_icb_cmd_ready),
      .agu_icb_cmd_addr  (agu_icb_cmd_addr),
      .agu_icb_cmd_read  (agu_icb_cmd_read),
      .agu_icb_cmd_wdata (agu_icb_cmd_wdata),
      .agu_icb_cmd_wmask (agu_icb_cmd_wmask),
      .agu_icb_cmd_size  (agu_icb_cmd_size),
      .agu_icb_cmd_usign (agu_icb_cmd_usign),
      .agu_icb_rsp_rdata (agu_icb_rsp_rdata),
      .lsu_o_valid       (lsu_o_valid),
      .lsu_o_ready       (lsu_o_ready),
      .lsu_o_wbck_wdat   (lsu_o_wbck_wdat),
      .lsu_o_cmt_ld      (lsu_o_cmt_ld),
      .lsu_o_cmt_st      (lsu_o_cmt_st),
      .lsu_o_misalgn     (lsu_o_misalgn),
      .mem_req_valid     (mem_req_valid),
      .mem_req_ready     (mem_req_ready),
      .mem_req_addr      (mem_req_addr),
      .mem_req_read      (mem_req_read),
      .mem_req_wdata     (mem_req_wdata),
      .mem_req_wmask     (mem_req_wmask),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_rdata     (mem_rsp_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        rd;
      logic [1:0]  size;
      logic        usign;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] word;
      int          req_stall;
      int          rsp_lat;
      int          wb_stall;
      logic [31:0] exp_wdat;
      logic        exp_mis;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] exp_rdata = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference load result: shift to the addressed lane, keep the access
   // width, then wrap values at or above the sign bit into negative numbers.
   function automatic logic [31:0] ref_load(input logic [31:0] w, input int lo,
                                            input int size, input logic us);
      logic [63:0] v;
      logic [63:0] span;
      int          bits;
      bits = (size == 0) ? 8 : (size == 1) ? 16 : 32;
      span = 64'd1 << bits;
      v    = {32'h0, w} / (64'd1 << (8 * lo));
      v    = v % span;
      if (!us && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // Runs one access starting at a negedge with the DUT idle; ends at the
   // negedge where the DUT is idle again.
   task automatic run_access(input vec_t v);
      check("cmd_ready_idle", agu_icb_cmd_ready, 32'd1);
      agu_icb_cmd_valid = 1'b1;
      agu_icb_cmd_addr  = v.addr;
      agu_icb_cmd_read  = v.rd;
      agu_icb_cmd_wdata = v.wdata;
      agu_icb_cmd_wmask = v.wmask;
      agu_icb_cmd_size  = v.size;
      agu_icb_cmd_usign = v.usign;
      @(negedge clk);
      // Scramble command inputs so only latched values can be seen later.
      agu_icb_cmd_valid = 1'b0;
      agu_icb_cmd_addr  = ~v.addr;
      agu_icb_cmd_wdata = ~v.wdata;
      agu_icb_cmd_wmask = ~v.wmask;
      agu_icb_cmd_read  = ~v.rd;
      check("cmd_ready_busy", agu_icb_cmd_ready, 32'd0);
      if (v.exp_mis) begin
         check("mis_no_req", mem_req_valid, 32'd0);
      end else begin
         check("req_valid", mem_req_valid, 32'd1);
         check("req_addr", mem_req_addr, v.addr & 32'hFFFF_FFFC);
         check("req_read", mem_req_read, v.rd);
         check("req_wdata", mem_req_wdata, v.wdata);
         check("req_wmask", mem_req_wmask, v.rd ? 32'd0 : v.wmask);
         for (int k = 0; k < v.req_stall; k++) begin
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;              // stray response, must be ignored
            mem_rsp_rdata = ~v.word;
            @(negedge clk);
            check("req_hold_valid", mem_req_valid, 32'd1);
            check("req_hold_addr", mem_req_addr, v.addr & 32'hFFFF_FFFC);
            check("req_hold_wdata", mem_req_wdata, v.wdata);
            check("req_hold_wmask", mem_req_wmask, v.rd ? 32'd0 : v.wmask);
         end
         mem_rsp_valid = 1'b0;
         mem_req_ready = 1'b1;
         @(negedge clk);
         mem_req_ready = 1'b0;
         for (int k = 1; k < v.rsp_lat; k++) begin
            check("wait_no_req", mem_req_valid, 32'd0);
            @(negedge clk);
         end
         check("wait_no_wb", lsu_o_valid, 32'd0);
         check("wait_no_req2", mem_req_valid, 32'd0);
         mem_rsp_valid = 1'b1;
         mem_rsp_rdata = v.word;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rsp_rdata = $urandom;
      end
      for (int k = 0; k <= v.wb_stall; k++) begin
         lsu_o_ready   = (k == v.wb_stall);
         mem_rsp_valid = (k != v.wb_stall);    // stray response in WBCK
         check("wb_valid", lsu_o_valid, 32'd1);
         check("wb_wdat", lsu_o_wbck_wdat, v.exp_wdat);
         check("wb_cmt_ld", lsu_o_cmt_ld, v.rd);
         check("wb_cmt_st", lsu_o_cmt_st, !v.rd);
         check("wb_misalgn", lsu_o_misalgn, v.exp_mis);
         check("wb_cmd_ready", agu_icb_cmd_ready, 32'd0);
         check("wb_no_req", mem_req_valid, 32'd0);
         @(negedge clk);
      end
      lsu_o_ready   = 1'b0;
      mem_rsp_valid = 1'b0;
      if (v.rd && !v.exp_mis) exp_rdata = v.exp_wdat;
      check("idle_no_wb", lsu_o_valid, 32'd0);
      check("rsp_rdata", agu_icb_rsp_rdata, exp_rdata);
   endtask

   vec_t vecs[12];
   vec_t rv;

   initial begin
      //           addr          rd    sz    us    wdata          wm    word           rs ln wb exp_wdat       mis
      vecs[0]  = '{32'h8000_0100, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 0, 1, 0, 32'hDEAD_BEEF, 1'b0};
      vecs[1]  = '{32'h8000_0103, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 4'h0, 32'h80FF_1234, 0, 1, 0, 32'hFFFF_FF80, 1'b0};
      vecs[2]  = '{32'h8000_0103, 1'b1, 2'd0, 1'b1, 32'h0000_0000, 4'h0, 32'h80FF_1234, 0, 2, 0, 32'h0000_0080, 1'b0};
      vecs[3]  = '{32'h8000_0102, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'h0, 32'h80FF_1234, 1, 1, 0, 32'hFFFF_80FF, 1'b0};
      vecs[4]  = '{32'h8000_0200, 1'b0, 2'd2, 1'b0, 32'h1122_3344, 4'hF, 32'h5555_AAAA, 3, 1, 0, 32'h0000_0000, 1'b0};
      vecs[5]  = '{32'h8000_0102, 1'b1, 2'd2, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 1'b1};
      vecs[6]  = '{32'h8000_0100, 1'b1, 2'd1, 1'b1, 32'h0000_0000, 4'h0, 32'h80FF_1234, 0, 1, 5, 32'h0000_1234, 1'b0};
      vecs[7]  = '{32'h8000_0101, 1'b1, 2'd0, 1'b0, 32'h0000_0000, 4'h0, 32'h80FF_1234, 0, 3, 0, 32'h0000_0012, 1'b0};
      vecs[8]  = '{32'h8000_0101, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_0000, 0, 1, 2, 32'h0000_0000, 1'b1};
      vecs[9]  = '{32'h8000_0203, 1'b0, 2'd0, 1'b0, 32'hAB00_0000, 4'h8, 32'h0000_0000, 0, 1, 1, 32'h0000_0000, 1'b0};
      vecs[10] = '{32'h8000_0100, 1'b1, 2'd1, 1'b0, 32'h0000_0000, 4'h0, 32'h0000_8001, 0, 1, 0, 32'hFFFF_8001, 1'b0};
      vecs[11] = '{32'h8000_0202, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 4'hF, 32'h0000_0000, 0, 1, 0, 32'h0000_0000, 1'b1};

      rst = 1'b1;
      agu_icb_cmd_valid = 1'b0;
      agu_icb_cmd_addr  = '0;
      agu_icb_cmd_read  = 1'b0;
      agu_icb_cmd_wdata = '0;
      agu_icb_cmd_wmask = '0;
      agu_icb_cmd_size  = 2'd0;
      agu_icb_cmd_usign = 1'b0;
      lsu_o_ready   = 1'b0;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      check("rst_cmd_ready", agu_icb_cmd_ready, 32'd1);
      check("rst_req_valid", mem_req_valid, 32'd0);
      check("rst_lsu_valid", lsu_o_valid, 32'd0);
      check("rst_rsp_rdata", agu_icb_rsp_rdata, 32'd0);
      check("rst_wdat", lsu_o_wbck_wdat, 32'd0);
      check("rst_cmt", {lsu_o_cmt_ld, lsu_o_cmt_st, lsu_o_misalgn}, 32'd0);
      check("rst_req_addr", mem_req_addr, 32'd0);
      check("rst_req_wmask", mem_req_wmask, 32'd0);

      // Directed table, chained back-to-back
      for (int i = 0; i < 12; i++) run_access(vecs[i]);

      // Randomized accesses against the reference model
      for (int i = 0; i < 60; i++) begin
         rv.rd        = $urandom_range(0, 1);
         rv.size      = 2'($urandom_range(0, 2));
         rv.usign     = $urandom_range(0, 1);
         rv.addr      = 32'h8000_0000 + ($urandom & 32'h0000_0FFF);
         rv.wdata     = $urandom;
         rv.wmask     = 4'($urandom);
         rv.word      = $urandom;
         rv.req_stall = $urandom_range(0, 2);
         rv.rsp_lat   = $urandom_range(1, 3);
         rv.wb_stall  = $urandom_range(0, 2);
         rv.exp_mis   = (rv.size == 2'd1 && (rv.addr % 2) != 0) ||
                        (rv.size == 2'd2 && (rv.addr % 4) != 0);
         rv.exp_wdat  = (rv.rd && !rv.exp_mis)
                        ? ref_load(rv.word, int'(rv.addr % 4), int'(rv.size), rv.usign)
                        : 32'h0;
         run_access(rv);
      end

      // Reset while waiting for the memory response; late response ignored
      check("rw_cmd_ready", agu_icb_cmd_ready, 32'd1);
      agu_icb_cmd_valid = 1'b1;
      agu_icb_cmd_addr  = 32'h8000_0300;
      agu_icb_cmd_read  = 1'b1;
      agu_icb_cmd_size  = 2'd2;
      agu_icb_cmd_usign = 1'b0;
      @(negedge clk);
      agu_icb_cmd_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check("rw_in_wait", mem_req_valid, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = 32'h0;
      @(negedge clk);
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = 32'hCAFE_F00D;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         check("rw_no_wb", lsu_o_valid, 32'd0);
         check("rw_cmd_ready", agu_icb_cmd_ready, 32'd1);
         check("rw_rsp_rdata", agu_icb_rsp_rdata, exp_rdata);
      end

      // Normal operation resumes after the aborted access
      run_access(vecs[0]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
